// File: rtl/high_score_tracker.sv
// high_score_tracker: tracks game sessions, keeps the best final score and games played, drives blinking 7-seg digits.
module high_score_tracker #(
    parameter int unsigned BLINK_HALF_PERIOD = 25000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] score,
    input  logic       gameStart,
    input  logic       gameOver,
    output logic [7:0] highScore,
    output logic       newRecord,
    output logic [7:0] gamesPlayed,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);
    typedef enum logic [1:0] {IDLE, PLAY, COMPARE, DONE} state_t;
    localparam int CW = BLINK_HALF_PERIOD > 2 ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF_PERIOD - 1);
    state_t state_q, state_d;
    logic [7:0] final_q, final_d, high_q, high_d, games_q, games_d;
    logic rec_q, rec_d, blank_q, blank_d;
    logic [CW-1:0] cnt_q, cnt_d;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction
    always_comb begin
        state_d = state_q;
        final_d = final_q;
        high_d  = high_q;
        games_d = games_q;
        rec_d   = rec_q;
        cnt_d   = rec_q ? ((cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1) : '0;
        blank_d = rec_q ? ((cnt_q == CNT_LAST) ? ~blank_q : blank_q) : 1'b0;
        case (state_q)
            IDLE: if (gameStart) begin
                state_d = PLAY;
                rec_d   = 1'b0;
            end
            PLAY: if (gameOver) begin
                state_d = COMPARE;
                final_d = score;
            end
            COMPARE: begin
                state_d = DONE;
                games_d = games_q + {7'd0, games_q != 8'hFF};
                if (final_q > high_q) begin
                    high_d = final_q;
                    rec_d  = 1'b1;
                end
            end
            default: if (gameStart) begin
                state_d = PLAY;
                rec_d   = 1'b0;
                cnt_d   = '0;
                blank_d = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            final_q <= '0;
            high_q  <= '0;
            games_q <= '0;
            rec_q   <= 1'b0;
            cnt_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            final_q <= final_d;
            high_q  <= high_d;
            games_q <= games_d;
            rec_q   <= rec_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
        end
    end
    assign highScore   = high_q;
    assign newRecord   = rec_q;
    assign gamesPlayed = games_q;
    assign HEX4 = blank_q ? 7'b1111111 : seg7(high_q[3:0]);
    assign HEX5 = blank_q ? 7'b1111111 : seg7(high_q[7:4]);
endmodule

// File: tb/tb_high_score_tracker.sv
// tb_high_score_tracker: directed scenarios with hand-computed expectations for high_score_tracker.
module tb_high_score_tracker;
    logic clk = 1'b0, resetn = 1'b0, gameStart = 1'b0, gameOver = 1'b0;
    logic [7:0] score = 8'd0;
    logic [7:0] highScore, gamesPlayed;
    logic newRecord;
    logic [6:0] HEX4, HEX5;
    int vecs = 0, errs = 0;
    localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S3 = 7'b0110000,
                           S5 = 7'b0010010, S8 = 7'b0000000, SC = 7'b1000110,
                           S9 = 7'b0010000, BL = 7'b1111111;

    high_score_tracker #(.BLINK_HALF_PERIOD(4)) dut (
        .clk(clk), .resetn(resetn), .score(score), .gameStart(gameStart), .gameOver(gameOver),
        .highScore(highScore), .newRecord(newRecord), .gamesPlayed(gamesPlayed), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start();
        gameStart = 1'b1;
        tick();
        gameStart = 1'b0;
    endtask
    task automatic over(input logic [7:0] s);
        score = s;
        gameOver = 1'b1;
        tick();
        gameOver = 1'b0;
        score = 8'd99;
    endtask
    task automatic play_game(input logic [7:0] s);
        start();
        over(s);
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        vecs++; if (highScore !== 8'd0) begin errs++; $display("FAIL reset_high: got %0d want 0", highScore); end
        vecs++; if (newRecord !== 1'b0) begin errs++; $display("FAIL reset_rec: got %b want 0", newRecord); end
        vecs++; if (gamesPlayed !== 8'd0) begin errs++; $display("FAIL reset_games: got %0d want 0", gamesPlayed); end
        vecs++; if ({HEX5, HEX4} !== {S0, S0}) begin errs++; $display("FAIL reset_hex: got %b %b want %b %b", HEX5, HEX4, S0, S0); end
    endtask

    task automatic test_first_record();
        start();
        over(8'd37);
        vecs++; if (highScore !== 8'd0 || gamesPlayed !== 8'd0) begin errs++; $display("FAIL latency_compare: got high %0d games %0d want 0 0", highScore, gamesPlayed); end
        tick();
        vecs++; if (highScore !== 8'd37) begin errs++; $display("FAIL first_high: got %0d want 37", highScore); end
        vecs++; if (newRecord !== 1'b1) begin errs++; $display("FAIL first_rec: got %b want 1", newRecord); end
        vecs++; if (gamesPlayed !== 8'd1) begin errs++; $display("FAIL first_games: got %0d want 1", gamesPlayed); end
        vecs++; if ({HEX5, HEX4} !== {S2, S5}) begin errs++; $display("FAIL first_hex: got %b %b want %b %b", HEX5, HEX4, S2, S5); end
    endtask

    task automatic test_equal_lower();
        start();
        vecs++; if (newRecord !== 1'b0) begin errs++; $display("FAIL start_clears_rec: got %b want 0", newRecord); end
        over(8'd37);
        tick();
        vecs++; if (highScore !== 8'd37 || newRecord !== 1'b0) begin errs++; $display("FAIL equal_score: got high %0d rec %b want 37 0", highScore, newRecord); end
        start();
        over(8'd20);
        tick();
        vecs++; if (highScore !== 8'd37 || newRecord !== 1'b0) begin errs++; $display("FAIL lower_score: got high %0d rec %b want 37 0", highScore, newRecord); end
        vecs++; if (gamesPlayed !== 8'd3) begin errs++; $display("FAIL three_games: got %0d want 3", gamesPlayed); end
    endtask

    task automatic test_blink();
        play_game(8'd50);
        for (int i = 0; i < 12; i++) begin
            logic [6:0] e4;
            e4 = ((i / 4) % 2 == 1) ? BL : S2;
            vecs++; if (HEX4 !== e4 || HEX5 !== (e4 == BL ? BL : S3)) begin errs++; $display("FAIL blink_cycle%0d: got %b %b want low %b", i, HEX5, HEX4, e4); end
            tick();
        end
        vecs++; if (HEX4 !== BL) begin errs++; $display("FAIL blink_before_start: got %b want %b", HEX4, BL); end
        start();
        vecs++; if ({HEX5, HEX4} !== {S3, S2} || newRecord !== 1'b0) begin errs++; $display("FAIL blink_stop: got %b %b rec %b want %b %b 0", HEX5, HEX4, newRecord, S3, S2); end
        for (int i = 0; i < 5; i++) tick();
        vecs++; if ({HEX5, HEX4} !== {S3, S2}) begin errs++; $display("FAIL blink_stays_off: got %b %b want %b %b", HEX5, HEX4, S3, S2); end
    endtask

    task automatic test_simultaneous();
        score = 8'd200;
        gameStart = 1'b1;
        gameOver = 1'b1;
        tick();
        gameStart = 1'b0;
        gameOver = 1'b0;
        score = 8'd1;
        tick();
        vecs++; if (highScore !== 8'd200 || newRecord !== 1'b1) begin errs++; $display("FAIL pair_in_play: got high %0d rec %b want 200 1", highScore, newRecord); end
        vecs++; if ({HEX5, HEX4} !== {SC, S8}) begin errs++; $display("FAIL pair_hex: got %b %b want %b %b", HEX5, HEX4, SC, S8); end
        vecs++; if (gamesPlayed !== 8'd5) begin errs++; $display("FAIL pair_games: got %0d want 5", gamesPlayed); end
        gameStart = 1'b1;
        gameOver = 1'b1;
        tick();
        gameStart = 1'b0;
        gameOver = 1'b0;
        tick();
        tick();
        vecs++; if (gamesPlayed !== 8'd5 || newRecord !== 1'b0) begin errs++; $display("FAIL pair_in_done: got games %0d rec %b want 5 0", gamesPlayed, newRecord); end
        over(8'd10);
        tick();
        vecs++; if (gamesPlayed !== 8'd6 || highScore !== 8'd200) begin errs++; $display("FAIL after_pair_play: got games %0d high %0d want 6 200", gamesPlayed, highScore); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 249; i++) play_game(8'd0);
        vecs++; if (gamesPlayed !== 8'd255) begin errs++; $display("FAIL games_255: got %0d want 255", gamesPlayed); end
        play_game(8'd255);
        vecs++; if (gamesPlayed !== 8'd255) begin errs++; $display("FAIL games_saturate: got %0d want 255", gamesPlayed); end
        vecs++; if (highScore !== 8'd255 || newRecord !== 1'b1) begin errs++; $display("FAIL max_score: got high %0d rec %b want 255 1", highScore, newRecord); end
        play_game(8'd255);
        vecs++; if (highScore !== 8'd255 || newRecord !== 1'b0) begin errs++; $display("FAIL max_again: got high %0d rec %b want 255 0", highScore, newRecord); end
    endtask

    task automatic test_reset_mid();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        play_game(8'd9);
        for (int i = 0; i < 4; i++) tick();
        vecs++; if (HEX4 !== BL || newRecord !== 1'b1) begin errs++; $display("FAIL pre_reset_blank: got %b rec %b want %b 1", HEX4, newRecord, BL); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        vecs++; if ({highScore, newRecord, gamesPlayed} !== 17'd0 || {HEX5, HEX4} !== {S0, S0}) begin errs++; $display("FAIL reset_in_blink: got high %0d rec %b games %0d hex %b %b", highScore, newRecord, gamesPlayed, HEX5, HEX4); end
        over(8'd77);
        tick();
        vecs++; if (highScore !== 8'd0 || gamesPlayed !== 8'd0) begin errs++; $display("FAIL idle_ignores_over: got high %0d games %0d want 0 0", highScore, gamesPlayed); end
        play_game(8'd9);
        start();
        over(8'd88);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        vecs++; if ({highScore, newRecord, gamesPlayed} !== 17'd0 || {HEX5, HEX4} !== {S0, S0}) begin errs++; $display("FAIL reset_in_compare: got high %0d rec %b games %0d hex %b %b", highScore, newRecord, gamesPlayed, HEX5, HEX4); end
        over(8'd66);
        tick();
        vecs++; if (highScore !== 8'd0 || gamesPlayed !== 8'd0) begin errs++; $display("FAIL over_after_reset: got high %0d games %0d want 0 0", highScore, gamesPlayed); end
        play_game(8'd9);
        vecs++; if (highScore !== 8'd9 || gamesPlayed !== 8'd1 || HEX4 !== S9) begin errs++; $display("FAIL recover_game: got high %0d games %0d hex %b want 9 1 %b", highScore, gamesPlayed, HEX4, S9); end
    endtask

    initial begin
        test_reset();
        test_first_record();
        test_equal_lower();
        test_blink();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/high_score_tracker.md
# high_score_tracker

Downstream consumer of the running 8-bit game score produced by the score-update stage. Tracks game sessions with a small FSM, latches the final score when a game ends, keeps the best score across games until reset, and counts games played. Drives two seven-segment digits with the high score and blinks them while a new record is being celebrated.

## Interface
- BLINK_HALF_PERIOD, default 25000000: clk cycles per blink half-phase; 0.5 s at 50 MHz. Legal range is 2 or more.
- clk  input  1  system clock; all state updates on its rising edge
- resetn  input  1  synchronous, active-low reset
- score  input  8  live score from the score-update stage, unsigned, saturates at 255 upstream
- gameStart  input  1  one-cycle pulse: a new game begins
- gameOver  input  1  one-cycle pulse: current game ended
- highScore  output  8  best final score since reset
- newRecord  output  1  high after a game that beat highScore; cleared on next gameStart
- gamesPlayed  output  8  completed games since reset, saturating at 255
- HEX4  output  7  high-score low nibble, active-low segments
- HEX5  output  7  high-score high nibble, active-low segments

## Operation
- FSM states are IDLE, PLAY, COMPARE and DONE. Reset forces IDLE.
- IDLE:
  - gameStart -> PLAY.
  - gameOver ignored.
- PLAY:
  - gameOver -> COMPARE; same edge captures score into an internal finalScore register.
  - gameStart ignored.
  - gameStart and gameOver together: gameOver wins.
- COMPARE lasts exactly one cycle, then -> DONE unconditionally. Actions:
  - If finalScore > highScore (strict), highScore <= finalScore and newRecord <= 1.
  - If finalScore equals or is below highScore, highScore and newRecord are unchanged.
  - gamesPlayed <= gamesPlayed + 1, held at 255 once reached; no wrap.
  - gameStart and gameOver are ignored in this state.
- DONE:
  - gameStart -> PLAY. Same edge clears newRecord, blink counter and blink phase.
  - gameOver ignored.
- Blink: while newRecord=1, a counter runs 0..BLINK_HALF_PERIOD-1 and toggles blankPhase on wrap.
  - blankPhase starts 0, i.e. visible, when newRecord rises.
  - While newRecord=0, counter and blankPhase are held at 0.
- HEX4 and HEX5 come from the team's seg7Display decoder on highScore[3:0] and highScore[7:4].
  - When blankPhase=1, both digits are forced to 7'b1111111 (all segments off).
- Arithmetic is unsigned 8-bit throughout; the comparison is unsigned.

## Timing
- Reset values:
  - state IDLE
  - highScore 0, gamesPlayed 0, newRecord 0
  - finalScore 0, blink counter 0, blankPhase 0
  - HEX4 and HEX5 both show the decoded digit 0 (7'b1000000)
- Reset asserted mid-game or mid-blink: everything returns to the reset values on that edge, including highScore.
- Latency, with gameOver sampled high in PLAY at edge N:
  - state = COMPARE after edge N.
  - highScore, newRecord and gamesPlayed update at edge N+1.
  - HEX outputs follow combinationally in the same cycle.
- gameStart sampled at edge M in IDLE or DONE: state = PLAY and newRecord = 0 after edge M.
- score is sampled only on the gameOver edge. Later changes to score do not affect the stored result.
- Blink phase toggles every BLINK_HALF_PERIOD cycles, counted from the first cycle newRecord=1.
- No pulse is buffered. A pulse arriving in a state that ignores it is lost.

## Test plan
1. Reset, then gameStart, score=37, gameOver -> two cycles later highScore=37, newRecord=1, gamesPlayed=1, HEX4/HEX5 show digits 5/2.
2. Second game with score=37 (equal), then a third with score=20 -> highScore stays 37, newRecord=0 after each gameStart, gamesPlayed=3.
3. With BLINK_HALF_PERIOD=4 and a new record -> HEX pattern is 4 cycles visible, 4 cycles 7'b1111111, repeating. gameStart stops the blink the next cycle with the digits visible.
4. gameStart and gameOver asserted together in PLAY with score=200 -> COMPARE entered and highScore=200. The same pair in DONE -> PLAY, no count change.
5. 256 games played -> gamesPlayed saturates at 255. A game with score=255 sets highScore=255; a later game with score=255 gives no new record.
6. resetn low during blink, and separately in COMPARE -> all outputs at reset values on the next edge, state IDLE, and a subsequent gameOver is ignored until gameStart.
